// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Misaligned (bit 0 set) or beyond the storage range once the word index is taken.
  function automatic logic addr_flagged(input logic [ADDR_W-1:0] addr, input int idx_w);
    return addr[0] || ((addr >> (idx_w + 1)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: async clear, one synchronous write port, one registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // The read register is the response bus: it carries data only the cycle after rd_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
    else            rd_data <= '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle handshaked data-memory target with stall output toward hazard detection.
// Optional DMEM_ERR_EN adds rsp_err for misaligned / out-of-range requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_stall
`ifdef DMEM_ERR_EN
  ,
  output logic              rsp_err
`endif
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              cap_we;
  logic              cap_err;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_wdata;

  logic              accept;
  logic              go_resp;
  logic              in_err;
  logic [IDX_W-1:0]  in_idx;
  logic              op_we;
  logic              op_err;
  logic [IDX_W-1:0]  op_idx;
  logic [DATA_W-1:0] op_wdata;
  logic              unused_addr_bits;

  assign accept = (state == S_IDLE) && req_valid;
  assign in_idx = req_addr[IDX_W:1];
  assign unused_addr_bits = ^{req_addr[0], (req_addr >> (IDX_W + 1))};

`ifdef DMEM_ERR_EN
  assign in_err = addr_flagged(req_addr, IDX_W);
`else
  assign in_err = 1'b0;
`endif

  // With LAT = 0 the access commits on the accepting edge, so the live request is used directly.
  assign go_resp  = (accept && (LAT == 0)) || ((state == S_WAIT) && (cnt == '0));
  assign op_we    = (state == S_IDLE) ? req_we    : cap_we;
  assign op_err   = (state == S_IDLE) ? in_err    : cap_err;
  assign op_idx   = (state == S_IDLE) ? in_idx    : cap_idx;
  assign op_wdata = (state == S_IDLE) ? req_wdata : cap_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_err   <= in_err;
            cap_idx   <= in_idx;
            cap_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            state     <= (LAT == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (go_resp && op_we && !op_err),
    .wr_idx  (op_idx),
    .wr_data (op_wdata),
    .rd_en   (go_resp && !op_we && !op_err),
    .rd_idx  (op_idx),
    .rd_data (rsp_rdata)
  );

`ifdef DMEM_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_err <= 1'b0;
    else       rsp_err <= go_resp && op_err;
  end
`endif

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign mem_stall = accept || (state == S_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance a uses LAT=2, instance b uses LAT=0.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int IDX_W = 8;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        sel = 1'b0;
  logic        va, vb;
  logic [1:0]  rdy, rv, stall;
  logic [15:0] rd_a, rd_b;
`ifdef DMEM_ERR_EN
  logic [1:0]  er;
`endif

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [1:0]  outst = 2'b00;
  logic [15:0] mdl [2][DEPTH];
  exp_t        q0[$];
  exp_t        q1[$];

  assign va = req_valid & ~sel;
  assign vb = req_valid & sel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(DEPTH), .LAT(2)) u_a (
    .clk(clk), .reset(reset), .req_valid(va), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy[0]), .rsp_valid(rv[0]), .rsp_rdata(rd_a),
    .mem_stall(stall[0])
`ifdef DMEM_ERR_EN
    , .rsp_err(er[0])
`endif
  );

  dmem_responder #(.DEPTH(DEPTH), .LAT(0)) u_b (
    .clk(clk), .reset(reset), .req_valid(vb), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy[1]), .rsp_valid(rv[1]), .rsp_rdata(rd_b),
    .mem_stall(stall[1])
`ifdef DMEM_ERR_EN
    , .rsp_err(er[1])
`endif
  );

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) mdl[s][i] = 16'h0;
    q0.delete();
    q1.delete();
    outst = 2'b00;
  endfunction

  // Reference: word index is the halfword address modulo DEPTH; flagged requests never touch memory.
  function automatic void model_accept(input int s, input logic we, input logic [15:0] a,
                                       input logic [15:0] d, input int acc);
    exp_t e;
    int   idx;
    logic err;
    idx = int'(a >> 1) % DEPTH;
    err = 1'b0;
`ifdef DMEM_ERR_EN
    err = a[0] || ((a >> (IDX_W + 1)) != 16'h0);
`endif
    e.err  = err;
    e.data = 16'h0;
    e.due  = acc + lat_of(s) + 1;
    if (we) begin
      if (!err) mdl[s][idx] = d;
    end else if (!err) begin
      e.data = mdl[s][idx];
    end
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic issue(input int s, input logic we, input logic [15:0] a, input logic [15:0] d);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    sel = (s == 1);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    @(negedge clk);
    while (!rdy[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[s]) begin
      chk("req_ready_timeout", {31'h0, rdy[s]}, 32'h1);
      req_valid = 1'b0;
    end else begin
      model_accept(s, we, a, d, cyc + 1);
      @(posedge clk);
      outst[s] = 1'b1;
      #1;
      // New address/data on the bus while the access is in flight must be ignored.
      req_valid = 1'b0;
      req_addr = 16'($urandom);
      req_wdata = 16'($urandom);
    end
  endtask

  task automatic mon(input int s);
    exp_t        e;
    logic        v;
    logic        vin;
    logic [15:0] d;
    logic        got_err;
    v   = rv[s];
    vin = (s == 0) ? va : vb;
    d   = (s == 0) ? rd_a : rd_b;
    got_err = 1'b0;
`ifdef DMEM_ERR_EN
    got_err = er[s];
`endif
    chk($sformatf("req_ready%0d", s), {31'h0, rdy[s]}, {31'h0, !outst[s]});
    chk($sformatf("mem_stall%0d", s), {31'h0, stall[s]},
        {31'h0, (vin && !outst[s]) || (outst[s] && !v)});
    if (!outst[s]) begin
      chk($sformatf("idle_rsp_valid%0d", s), {31'h0, v}, 32'h0);
      chk($sformatf("idle_rdata%0d", s), {16'h0, d}, 32'h0);
    end else if (v) begin
      if (s == 0 && q0.size() > 0)      e = q0.pop_front();
      else if (s == 1 && q1.size() > 0) e = q1.pop_front();
      else begin
        e.data = 16'h0; e.err = 1'b0; e.due = -1;
      end
      chk($sformatf("rsp_rdata%0d", s), {16'h0, d}, {16'h0, e.data});
      chk($sformatf("rsp_err%0d", s), {31'h0, got_err}, {31'h0, e.err});
      chk($sformatf("rsp_edge%0d", s), cyc + 1, e.due);
      outst[s] = 1'b0;
    end else begin
      chk($sformatf("wait_rdata%0d", s), {16'h0, d}, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) mon(s);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {30'h0, rdy}, 32'h3);
    chk("rst_rsp_valid", {30'h0, rv}, 32'h0);
    chk("rst_stall", {30'h0, stall}, 32'h0);
    chk("rst_rdata", {rd_a, rd_b}, 32'h0);

    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    issue(0, 1'b0, 16'h0010, 16'h0000);
    issue(1, 1'b1, 16'h0000, 16'h1111);
    issue(1, 1'b1, 16'h0002, 16'h2222);
    issue(1, 1'b0, 16'h0000, 16'h0000);
    issue(1, 1'b0, 16'h0002, 16'h0000);
    issue(0, 1'b1, 16'h0204, 16'hA5A5);
    issue(0, 1'b0, 16'h0004, 16'h0000);

    for (int i = 0; i < 80; i++) begin
      issue(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom) & 16'h061F, 16'($urandom));
    end

    // Reset while a store sits in WAIT: it must never respond nor commit.
    issue(0, 1'b1, 16'h0020, 16'h1234);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    chk("mid_rst_ready", {31'h0, rdy[0]}, 32'h1);
    chk("mid_rst_rsp_valid", {31'h0, rv[0]}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue(0, 1'b0, 16'h0020, 16'h0000);
    issue(1, 1'b0, 16'h0002, 16'h0000);

    n = 0;
    while (outst != 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", {30'h0, outst}, 32'h0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
